// File: rtl/cnn_obi_mem_sbr.sv
`default_nettype none
// ------------------------------------------------------------------------------
// cnn_obi_mem_sbr: word-addressed OBI scratchpad subordinate with programmable grant delay.
// Revision: 1.0
// ------------------------------------------------------------------------------

package obi_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
    bit          UseRReady;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4, UseRReady: 1'b0};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;
endpackage

module cnn_obi_mem_sbr #(
  parameter obi_pkg::obi_cfg_t ObiCfg     = obi_pkg::ObiDefaultConfig,
  parameter int unsigned       NumWords   = 256,
  parameter logic [31:0]       BaseAddr   = 32'h1A10_0000,
  parameter int unsigned       WaitCycles = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  obi_pkg::obi_req_t obi_req_i,
  output obi_pkg::obi_rsp_t obi_rsp_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned IdxW        = $clog2(NumWords);
  localparam logic [2:0]  c_wait_load = (WaitCycles > 0) ? 3'(WaitCycles - 1) : 3'd0;

  if (ObiCfg.AddrWidth != 32 || ObiCfg.DataWidth != 32 || NumWords < 16 || NumWords > 1024 ||
      (NumWords & (NumWords - 1)) != 0 || WaitCycles > 7 || BaseAddr[1:0] != 2'b00) begin : g_bad_cfg
    $error("cnn_obi_mem_sbr: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic            rvalid_q;
  logic [31:0]     rdata_q;
  logic [3:0]      rid_q;
  logic            err_q;
  logic            err_pulse_q;
  logic [31:0]     mem_q [NumWords];

  logic [29:0]     w_off;
  logic [IdxW-1:0] w_idx;
  logic            w_dec_err;
  logic            w_gnt;
  logic [31:0]     rdata_d;

  // Word offset is taken on word addresses; out-of-window hits show up in the upper offset bits.
  assign w_off     = obi_req_i.a.addr[31:2] - BaseAddr[31:2];
  assign w_idx     = w_off[IdxW-1:0];
  assign w_dec_err = (obi_req_i.a.addr < BaseAddr) | (|w_off[29:IdxW]) | (|obi_req_i.a.addr[1:0]);
  assign rdata_d   = (w_dec_err || obi_req_i.a.we) ? 32'h0 : mem_q[w_idx];

  always_comb begin
    w_gnt = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE, RESP: w_gnt = (WaitCycles == 0) && obi_req_i.req;
        WAIT:       w_gnt = obi_req_i.req && (cnt_q == 3'd0);
        default:    w_gnt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
      rid_q       <= 4'h0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      for (int unsigned i = 0; i < NumWords; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      rvalid_q    <= w_gnt;
      err_pulse_q <= w_gnt & w_dec_err;
      if (w_gnt) begin
        rid_q   <= obi_req_i.a.aid;
        err_q   <= w_dec_err;
        rdata_q <= rdata_d;
        if (obi_req_i.a.we && !w_dec_err) begin
          for (int k = 0; k < 4; k++) begin
            if (obi_req_i.a.be[k]) mem_q[w_idx][8*k +: 8] <= obi_req_i.a.wdata[8*k +: 8];
          end
        end
      end
      case (state_q)
        IDLE, RESP: begin
          if (w_gnt) begin
            state_q <= RESP;
          end else if (obi_req_i.req) begin
            state_q <= WAIT;
            cnt_q   <= c_wait_load;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          // A dropped request abandons the access without touching memory.
          if (!obi_req_i.req)  state_q <= IDLE;
          else if (w_gnt)      state_q <= RESP;
          else                 cnt_q   <= cnt_q - 3'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = w_gnt;
    obi_rsp_o.rvalid       = rvalid_q;
    obi_rsp_o.r.rdata      = rdata_q;
    obi_rsp_o.r.rid        = rid_q;
    obi_rsp_o.r.err        = err_q;
    obi_rsp_o.r.r_optional = 1'b0;
  end

  assign busy_o = (state_q == WAIT) || (state_q == RESP);
  assign err_o  = err_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_obi_mem_sbr.sv
`default_nettype none
// Bench for cnn_obi_mem_sbr: a zero-wait instance driven from a vector table with a response
// scoreboard, and a three-wait instance exercised by hand-written timing sequences.
module tb_cnn_obi_mem_sbr;

  logic clk;
  logic rst0_n, rst3_n;
  obi_pkg::obi_req_t req0, req3;
  obi_pkg::obi_rsp_t rsp0, rsp3;
  logic busy0, busy3, erro0, erro3;

  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } exp_t;

  vec_t vecs [16];
  exp_t sbq[$];
  exp_t mon_e;

  cnn_obi_mem_sbr #(.NumWords(256), .BaseAddr(32'h1A10_0000), .WaitCycles(0)) dut0 (
    .clk_i(clk), .rst_ni(rst0_n), .obi_req_i(req0), .obi_rsp_o(rsp0), .busy_o(busy0), .err_o(erro0));

  cnn_obi_mem_sbr #(.NumWords(256), .BaseAddr(32'h1A10_0000), .WaitCycles(3)) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .obi_req_i(req3), .obi_rsp_o(rsp3), .busy_o(busy3), .err_o(erro3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer for the zero-wait instance.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (rsp0.rvalid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_rdata", rsp0.r.rdata, mon_e.rdata);
          chk("rsp_rid", 32'(rsp0.r.rid), 32'(mon_e.rid));
          chk("rsp_err", 32'(rsp0.r.err), 32'(mon_e.err));
          chk("rsp_err_o", 32'(erro0), 32'(mon_e.err));
          chk("rsp_busy", 32'(busy0), 32'd1);
          chk("rsp_r_optional", 32'(rsp0.r.r_optional), 32'd0);
        end
      end else begin
        chk("err_o_idle", 32'(erro0), 32'd0);
      end
    end
  end

  task automatic issue0(input vec_t v);
    exp_t e;
    @(negedge clk);
    req0.req     = 1'b1;
    req0.a.we    = v.we;
    req0.a.addr  = v.addr;
    req0.a.be    = v.be;
    req0.a.wdata = v.wdata;
    req0.a.aid   = v.aid;
    #1;
    chk("gnt0_same_cycle", 32'(rsp0.gnt), 32'd1);
    e.rdata = v.exp_rdata;
    e.rid   = v.aid;
    e.err   = v.exp_err;
    sbq.push_back(e);
  endtask

  task automatic txn3(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic [3:0] aid,
                      output logic ok, output logic [31:0] rd);
    int n;
    @(negedge clk);
    req3.req = 1'b1; req3.a.we = we; req3.a.addr = addr; req3.a.be = be;
    req3.a.wdata = wd; req3.a.aid = aid;
    n = 0; ok = 1'b0; rd = 32'h0;
    while (n < 20) begin
      #1;
      if (rsp3.gnt) begin ok = 1'b1; break; end
      @(negedge clk);
      n++;
    end
    if (!ok) begin
      req3.req = 1'b0;
      return;
    end
    @(negedge clk);
    req3.req = 1'b0;
    #1;
    ok = rsp3.rvalid;
    rd = rsp3.r.rdata;
  endtask

  initial begin
    logic ok;
    logic [31:0] rd;

    vecs[0]  = '{1'b1, 32'h1A10_0010, 4'hF, 32'hCAFE_F00D, 4'd3,  32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h1A10_0010, 4'h0, 32'h0,         4'd1,  32'hCAFE_F00D, 1'b0};
    vecs[2]  = '{1'b1, 32'h1A10_0020, 4'hF, 32'h1122_3344, 4'd2,  32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h1A10_0020, 4'h2, 32'h0000_AB00, 4'd4,  32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h1A10_0020, 4'h0, 32'h0,         4'd5,  32'h1122_AB44, 1'b0};
    vecs[5]  = '{1'b0, 32'h1A10_0400, 4'h0, 32'h0,         4'd6,  32'h0,         1'b1};
    vecs[6]  = '{1'b0, 32'h1A10_0002, 4'h0, 32'h0,         4'd7,  32'h0,         1'b1};
    vecs[7]  = '{1'b1, 32'h1A10_0400, 4'hF, 32'hDEAD_BEEF, 4'd8,  32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'h1A0F_FFFC, 4'hF, 32'hDEAD_BEEF, 4'd9,  32'h0,         1'b1};
    vecs[9]  = '{1'b0, 32'h1A10_0000, 4'h0, 32'h0,         4'd0,  32'h0,         1'b0};
    vecs[10] = '{1'b0, 32'h1A10_03FC, 4'h0, 32'h0,         4'd10, 32'h0,         1'b0};
    vecs[11] = '{1'b1, 32'h1A10_0020, 4'h0, 32'hFFFF_FFFF, 4'd11, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'h1A10_0020, 4'h0, 32'h0,         4'd12, 32'h1122_AB44, 1'b0};
    vecs[13] = '{1'b1, 32'h1A10_0000, 4'h9, 32'hA5A5_A5A5, 4'd13, 32'h0,         1'b0};
    vecs[14] = '{1'b0, 32'h1A10_0000, 4'h0, 32'h0,         4'd14, 32'hA500_00A5, 1'b0};
    vecs[15] = '{1'b0, 32'h1A10_0010, 4'h0, 32'h0,         4'd15, 32'hCAFE_F00D, 1'b0};

    // Reset with a live request: grant must stay low.
    rst0_n = 1'b0; rst3_n = 1'b0;
    req0 = '0; req3 = '0;
    req0.req = 1'b1; req0.a.addr = 32'h1A10_0010;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_gnt", 32'(rsp0.gnt), 32'd0);
    chk("reset_rvalid", 32'(rsp0.rvalid), 32'd0);
    chk("reset_rdata", rsp0.r.rdata, 32'h0);
    chk("reset_rid", 32'(rsp0.r.rid), 32'd0);
    chk("reset_err", 32'(rsp0.r.err), 32'd0);
    chk("reset_err_o", 32'(erro0), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_busy3", 32'(busy3), 32'd0);
    @(negedge clk);
    rst0_n = 1'b1; rst3_n = 1'b1; req0.req = 1'b0;
    mon_en = 1'b1;

    // Zero-wait table, issued back-to-back.
    for (int i = 0; i < 16; i++) issue0(vecs[i]);
    @(negedge clk);
    req0.req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("idle_busy0", 32'(busy0), 32'd0);

    // Three-wait timing: gnt only at cycle 3, rvalid at 4, busy over 1..4.
    @(negedge clk);
    req3.req = 1'b1; req3.a.we = 1'b1; req3.a.addr = 32'h1A10_0030;
    req3.a.be = 4'hF; req3.a.wdata = 32'h1234_5678; req3.a.aid = 4'd5;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) req3.req = 1'b0;
      #1;
      chk($sformatf("w3_gnt_c%0d", c), 32'(rsp3.gnt), 32'(c == 3));
      chk($sformatf("w3_rvalid_c%0d", c), 32'(rsp3.rvalid), 32'(c == 4));
      chk($sformatf("w3_busy_c%0d", c), 32'(busy3), 32'(c >= 1 && c <= 4));
      if (c == 4) begin
        chk("w3_rid", 32'(rsp3.r.rid), 32'd5);
        chk("w3_err", 32'(rsp3.r.err), 32'd0);
        chk("w3_wr_rdata", rsp3.r.rdata, 32'h0);
      end
      @(negedge clk);
    end
    txn3(1'b0, 32'h1A10_0030, 4'h0, 32'h0, 4'd6, ok, rd);
    chk("w3_rd_valid", 32'(ok), 32'd1);
    chk("w3_rd_data", rd, 32'h1234_5678);

    // Request abandoned in WAIT: no grant, no response, memory untouched.
    @(negedge clk);
    req3.req = 1'b1; req3.a.we = 1'b1; req3.a.addr = 32'h1A10_0030;
    req3.a.be = 4'hF; req3.a.wdata = 32'h0000_0BAD; req3.a.aid = 4'd7;
    @(negedge clk);
    req3.req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("abandon_gnt_c%0d", c), 32'(rsp3.gnt), 32'd0);
      chk($sformatf("abandon_rvalid_c%0d", c), 32'(rsp3.rvalid), 32'd0);
      chk($sformatf("abandon_busy_c%0d", c), 32'(busy3), 32'(c == 0));
      @(negedge clk);
    end
    txn3(1'b0, 32'h1A10_0030, 4'h0, 32'h0, 4'd8, ok, rd);
    chk("abandon_rd_valid", 32'(ok), 32'd1);
    chk("abandon_rd_data", rd, 32'h1234_5678);

    // Reset landing on the would-be grant cycle of a pending write.
    @(negedge clk);
    req3.req = 1'b1; req3.a.we = 1'b1; req3.a.addr = 32'h1A10_0034;
    req3.a.be = 4'hF; req3.a.wdata = 32'hFFFF_FFFF; req3.a.aid = 4'd9;
    repeat (2) @(negedge clk);
    rst3_n = 1'b0;
    #1;
    chk("rstwait_gnt", 32'(rsp3.gnt), 32'd0);
    @(negedge clk);
    rst3_n = 1'b1; req3.req = 1'b0;
    #1;
    chk("rstwait_rvalid", 32'(rsp3.rvalid), 32'd0);
    chk("rstwait_busy", 32'(busy3), 32'd0);
    chk("rstwait_err_o", 32'(erro3), 32'd0);
    chk("rstwait_rdata", rsp3.r.rdata, 32'h0);
    chk("rstwait_rid", 32'(rsp3.r.rid), 32'd0);
    chk("rstwait_err", 32'(rsp3.r.err), 32'd0);
    @(negedge clk); #1;
    chk("rstwait_no_late_rvalid", 32'(rsp3.rvalid), 32'd0);
    txn3(1'b0, 32'h1A10_0034, 4'h0, 32'h0, 4'd1, ok, rd);
    chk("rstwait_rd_valid", 32'(ok), 32'd1);
    chk("rstwait_rd_data", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
